par_read_fifo: RTL and testbench

PAR_READ_FIFO -- requirements
Module: par_read_fifo

---
 rtl/par_read_fifo.sv | 85 ++++++++
 tb/tb_par_read_fifo.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/par_read_fifo.sv
// Single-clock FIFO: one word written per cycle, PAR_READ words read per cycle.
// Read data is show-ahead; the oldest word sits in the low slice of dout.
module par_read_fifo #(
   parameter int unsigned NUM_BIT   = 4,
   parameter int unsigned NUM_REG   = 4,
   parameter int unsigned PAR_WRITE = 1,
   parameter int unsigned PAR_READ  = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          init,
   input  logic                          wen,
   input  logic [PAR_WRITE*NUM_BIT-1:0]  din,
   input  logic                          ren,
   output logic [PAR_READ*NUM_BIT-1:0]   dout,
   output logic                          ready,
   output logic                          valid,
   output logic                          full,
   output logic                          empty
);

   localparam int unsigned AW = $clog2(NUM_REG);
   localparam int unsigned PW = AW + 1;

   logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]      occ;
   logic [NUM_BIT-1:0] mem_q [NUM_REG];
   logic [NUM_BIT-1:0] mem_d [NUM_REG];
   logic               wr_acc;
   logic               rd_acc;
   logic [AW-1:0]      rd_addr;

   // Extra wrap bit on each pointer lets occupancy reach NUM_REG unambiguously.
   assign occ   = wr_ptr_q - rd_ptr_q;
   assign ready = (occ <= PW'(NUM_REG - PAR_WRITE));
   assign valid = (occ >= PW'(PAR_READ));
   assign full  = (occ == PW'(NUM_REG));
   assign empty = (occ == '0);

   assign wr_acc = wen & ready & ~init;
   assign rd_acc = ren & valid & ~init;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;
      if (init) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (wr_acc) begin
            mem_d[wr_ptr_q[AW-1:0]] = din[NUM_BIT-1:0];
            wr_ptr_d = wr_ptr_q + PW'(1);
         end
         if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PW'(PAR_READ);
         end
      end
   end

   always_comb begin
      dout    = '0;
      rd_addr = '0;
      for (int k = 0; k < PAR_READ; k++) begin
         rd_addr = rd_ptr_q[AW-1:0] + AW'(k);
         dout[k*NUM_BIT +: NUM_BIT] = mem_q[rd_addr];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < NUM_REG; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: tb/tb_par_read_fifo.sv
// Directed bench for par_read_fifo: expected read pairs go into a queue,
// a monitor pops and compares on every accepted read.
module tb_par_read_fifo;

   logic       clk;
   logic       rst;
   logic       init;
   logic       wen;
   logic [3:0] din;
   logic       ren;
   logic [7:0] dout;
   logic       ready;
   logic       valid;
   logic       full;
   logic       empty;

   int total = 0;
   int bad   = 0;
   logic [7:0] exp_q[$];

   par_read_fifo #(
      .NUM_BIT  (4),
      .NUM_REG  (4),
      .PAR_WRITE(1),
      .PAR_READ (2)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .init (init),
      .wen  (wen),
      .din  (din),
      .ren  (ren),
      .dout (dout),
      .ready(ready),
      .valid(valid),
      .full (full),
      .empty(empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Called at a falling edge: apply inputs, then wait across the rising edge.
   task automatic step(input logic w, input logic [3:0] d, input logic r,
                       input logic rs, input logic in);
      wen  = w;
      din  = d;
      ren  = r;
      rst  = rs;
      init = in;
      @(negedge clk);
   endtask

   task automatic wr(input logic [3:0] d);
      step(1'b1, d, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic rd(input logic [7:0] e);
      exp_q.push_back(e);
      step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
   endtask

   // Monitor: samples the pre-edge handshake between the falling and rising edges.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (!rst && !init && ren && valid) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_read: got %0h expected no read", dout);
            end else begin
               chk("read_data", {24'h0, dout}, {24'h0, exp_q.pop_front()});
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; init = 1'b0; wen = 1'b0; ren = 1'b0; din = 4'h0;
      @(negedge clk);
      step(1'b1, 4'hF, 1'b1, 1'b1, 1'b0);
      step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_ready", ready, 1);
      chk("rst_valid", valid, 0);
      chk("rst_dout", dout, 0);

      // Two writes form the first pair
      wr(4'hA);
      chk("one_valid", valid, 0);
      chk("one_empty", empty, 0);
      wr(4'hB);
      chk("two_valid", valid, 1);
      chk("two_dout", dout, 8'hBA);
      chk("two_empty", empty, 0);
      chk("two_full", full, 0);
      rd(8'hBA);
      chk("drain_empty", empty, 1);

      // Fill to full, overflow write ignored, addresses wrap
      wr(4'h1); wr(4'h2); wr(4'h3); wr(4'h4);
      chk("full_full", full, 1);
      chk("full_ready", ready, 0);
      wr(4'h5);
      chk("ovf_full", full, 1);
      chk("ovf_dout", dout, 8'h21);
      rd(8'h21);
      chk("rd1_dout", dout, 8'h43);
      chk("rd1_valid", valid, 1);
      rd(8'h43);
      chk("rd2_empty", empty, 1);
      chk("rd2_valid", valid, 0);

      // Single word never yields a partial read
      wr(4'h7);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
         chk("partial_valid", valid, 0);
         chk("partial_empty", empty, 0);
      end
      wr(4'h8);
      chk("partial_dout", dout, 8'h87);
      rd(8'h87);
      chk("partial_drain", empty, 1);

      // Wrap-around sequence leaving one word behind
      wr(4'h1); wr(4'h2); wr(4'h3);
      rd(8'h21);
      wr(4'h4); wr(4'h5);
      rd(8'h43);
      step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
      chk("wrap_valid", valid, 0);
      chk("wrap_empty", empty, 0);
      wr(4'h6);
      chk("wrap_dout", dout, 8'h65);
      rd(8'h65);
      chk("wrap_drain", empty, 1);

      // Simultaneous read/write at full and at occupancy 2
      wr(4'h9); wr(4'hA); wr(4'hB); wr(4'hC);
      chk("sim_full", full, 1);
      exp_q.push_back(8'hA9);
      step(1'b1, 4'hD, 1'b1, 1'b0, 1'b0);
      chk("sim_full_after", full, 0);
      chk("sim_valid", valid, 1);
      chk("sim_dout", dout, 8'hCB);
      exp_q.push_back(8'hCB);
      step(1'b1, 4'hD, 1'b1, 1'b0, 1'b0);
      chk("sim2_valid", valid, 0);
      chk("sim2_empty", empty, 0);
      wr(4'hE);
      chk("sim3_dout", dout, 8'hED);
      rd(8'hED);
      chk("sim3_empty", empty, 1);

      // Reset mid-operation discards data
      wr(4'h1); wr(4'h2); wr(4'h3);
      step(1'b1, 4'h4, 1'b1, 1'b1, 1'b0);
      step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      chk("mrst_empty", empty, 1);
      chk("mrst_valid", valid, 0);
      chk("mrst_dout", dout, 0);

      // Init clears pointers only; buffer contents survive
      wr(4'h1); wr(4'h2); wr(4'h3);
      step(1'b1, 4'h4, 1'b1, 1'b0, 1'b1);
      step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      chk("init_empty", empty, 1);
      chk("init_valid", valid, 0);
      chk("init_dout_kept", dout, 8'h21);
      wr(4'h4); wr(4'h5);
      chk("init_new_dout", dout, 8'h54);
      rd(8'h54);
      chk("init_drain", empty, 1);

      step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      chk("reads_outstanding", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
